// File: rtl/rpn_alu_pkg.sv
// Shared definitions for the RPN ALU: divider state encoding and constants.
package rpn_alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int          DIV_ITERATIONS       = 8;
    localparam logic [7:0]  DBZ_QUOTIENT_DEFAULT = 8'hFF;

endpackage

// File: rtl/rpn_div_sequencer_if.sv
// Launch/result bundle between the RPN operation decoder and the divider.
interface rpn_div_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/A_8bits_fullsubtractor.sv
// 8-bit ripple-borrow subtractor: Diff = A - B - Bi, Bo is the borrow out.
module A_8bits_fullsubtractor (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Bi,
    output logic [7:0] Diff,
    output logic       Bo
);
    logic [8:0] borrow_s;

    assign borrow_s[0] = Bi;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign Diff[i]        = A[i] ^ B[i] ^ borrow_s[i];
        assign borrow_s[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & borrow_s[i]);
    end

    assign Bo = borrow_s[8];
endmodule

// File: rtl/rpn_div_sequencer.sv
// Multi-cycle restoring 8-bit unsigned divider sharing one ripple subtractor
// for every trial subtraction; returns quotient/remainder with a done strobe.
module rpn_div_sequencer
    import rpn_alu_pkg::*;
#(
    parameter int         WIDTH        = 8,
    parameter logic [7:0] DBZ_QUOTIENT = DBZ_QUOTIENT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    rpn_div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(DIV_ITERATIONS);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;
    logic             borrow_s;
    logic             take_s;

    // R[7] is the ninth trial bit: when set the trial value is >= 256 > D,
    // so the subtraction always succeeds and Diff is exact modulo 256.
    assign shift_s  = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign take_s   = r_q[WIDTH-1] | ~borrow_s;
    assign r_next_s = take_s ? diff_s : shift_s;
    assign q_next_s = {q_q[WIDTH-2:0], take_s};

    A_8bits_fullsubtractor u_trial_sub (
        .A    (shift_s),
        .B    (d_q),
        .Bi   (1'b0),
        .Diff (diff_s),
        .Bo   (borrow_s)
    );

    // Sequencer FSM, datapath shift registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_q   <= '0;
                        q_q   <= bus.dividend;
                        d_q   <= bus.divisor;
                        cnt_q <= CNT_W'(DIV_ITERATIONS - 1);
                        if (bus.divisor == '0) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= ST_ITER;
                            busy_q  <= 1'b1;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                ST_ITER: begin
                    r_q   <= r_next_s;
                    q_q   <= q_next_s;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_next_s;
                        remainder_q <= r_next_s;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
